tcnt_count_channel: RTL and testbench
=====================================

// Module: tcnt_count_channel
// PURPOSE
//  Consumer of the per-channel count-enable pulse: one timer channel's TCNT counter, compare A/B match
//  detection, clear control, overflow, sticky status flags and TMO pin generation. Sits between the
//  clock-select channel (drives i_tcnt_en) and the APB register block; o_cascade feeds the next channel.
// PARAMETERS
//  WIDTH      8     counter/compare width in bits
//  TMO_RST    1'b0  reset level of o_tmo
// PORTS
//  i_clk         in   1      timer clock; single clock domain
//  i_rst_n       in   1      reset, synchronous, active-low
//  i_tcnt_en     in   1      count pulse, one i_clk wide, from clock select
//  i_tcnt_wr     in   1      APB write strobe to TCNT
//  i_tcnt_wdata  in   WIDTH  TCNT write data
//  i_tcora       in   WIDTH  compare register A (held by register block)
//  i_tcorb       in   WIDTH  compare register B
//  i_cclr        in   2      clear select: 00 none, 01 on match A, 10 on match B, 11 on i_tmri
//  i_tmri        in   1      external reset event pulse (already edge-detected)
//  i_os          in   4      [1:0] action on match A, [3:2] on match B: 00 none, 01 low, 10 high, 11 toggle
//  i_flag_clr    in   3      clear strobes {OVF, CMFB, CMFA}
//  o_tcnt        out  WIDTH  current counter value
//  o_cmfa        out  1      sticky compare-match-A flag
//  o_cmfb        out  1      sticky compare-match-B flag
//  o_ovf         out  1      sticky overflow flag
//  o_cmia_pulse  out  1      one-cycle compare-match-A event
//  o_ovf_pulse   out  1      one-cycle overflow event
//  o_cascade     out  1      = o_ovf_pulse (next channel's cascaded input)
//  o_tmo         out  1      timer output pin
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge): o_tcnt=0, all flags/pulses 0, o_tmo=TMO_RST. Reset overrides all.
//  - Count event = i_tcnt_en & ~i_tcnt_wr. Match A = count event & (tcnt==i_tcora); B likewise.
//    Match compares the PRE-increment value; match effects and next value take effect next edge.
//  - Next-TCNT priority: i_tcnt_wr -> i_tcnt_wdata; else cclr=11 & i_tmri -> 0;
//    else count event & selected match (cclr 01/10) -> 0; else count event -> tcnt+1 (mod 2^WIDTH);
//    else hold.
//  - Overflow: count event with tcnt=all-ones and no clear taken -> wraps to 0, o_ovf_pulse=1 one cycle.
//    Clear-on-match at all-ones suppresses overflow.
//  - Write cycle inhibits counting and compare match for that cycle (write wins over i_tcnt_en).
//  - Flags: set on event, cleared by i_flag_clr bit; same-cycle set and clear -> set wins.
//  - Pulses o_cmia_pulse/o_ovf_pulse registered: high exactly the cycle after the event edge, 1 cycle.
//  - TMO: applies i_os actions registered with match. Simultaneous A and B match: B action wins
//    except when B action is 00 (then A applies). Toggle inverts current o_tmo.
//  - i_tmri with cclr!=11 ignored. i_tcnt_en while in reset ignored; no pending state survives reset.
//  - Compare registers may change any cycle; compare uses current input values.
// STRUCTURE
//  - Shared package timer_pkg: cclr_e {CCLR_NONE,CCLR_CMA,CCLR_CMB,CCLR_TMRI}, os_e
//    {OS_NONE,OS_LOW,OS_HIGH,OS_TOGGLE}, flag index constants.
//  - One sub-module: tmo_out_ctrl (match A/B + os_e pair -> registered o_tmo, priority rule above).
//  - Counter, match, flag logic inline in this module.
// TESTING
//  1. TCORA=0x05, cclr=01, enable every cycle from 0 -> TCNT 0..5,0,..; o_cmia_pulse after each 5; CMFA set.
//  2. cclr=00, TCNT written 0xFE, two count pulses -> 0xFF then 0x00, o_ovf_pulse/o_cascade 1 cycle, OVF=1.
//  3. i_tcnt_wr=1 data 0x40 with i_tcnt_en=1 and TCNT==TCORA -> TCNT=0x40, no match, no increment.
//  4. OVF set, i_flag_clr[2]=1 same cycle as new overflow -> OVF stays 1; next cycle clear alone -> 0.
//  5. TCORA=TCORB=0x10, os=4'b11_10 -> B toggle wins; o_tmo inverts each match; os[3:2]=00 -> goes high.
//  6. cclr=11, i_tmri at TCNT=0x33 -> TCNT=0; mid-count i_rst_n=0 one cycle -> TCNT=0, flags 0, o_tmo=TMO_RST.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer channel blocks.
package timer_pkg;

   typedef enum logic [1:0] {
      CCLR_NONE = 2'b00,
      CCLR_CMA  = 2'b01,
      CCLR_CMB  = 2'b10,
      CCLR_TMRI = 2'b11
   } cclr_e;

   typedef enum logic [1:0] {
      OS_NONE   = 2'b00,
      OS_LOW    = 2'b01,
      OS_HIGH   = 2'b10,
      OS_TOGGLE = 2'b11
   } os_e;

   // Bit positions inside the {OVF, CMFB, CMFA} flag vector
   localparam int FLAG_CMFA = 0;
   localparam int FLAG_CMFB = 1;
   localparam int FLAG_OVF  = 2;
   localparam int NUM_FLAGS = 3;

   // Pin level that results from applying one output action to the current level
   function automatic logic apply_os(input os_e act, input logic cur);
      logic nxt;
      case (act)
         OS_LOW:    nxt = 1'b0;
         OS_HIGH:   nxt = 1'b1;
         OS_TOGGLE: nxt = ~cur;
         default:   nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tmo_out_ctrl.sv
// Timer output pin: resolves the compare A/B output actions into a registered pin level.
module tmo_out_ctrl
   import timer_pkg::*;
#(
   parameter logic TMO_RST = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_match_a,
   input  logic i_match_b,
   input  os_e  i_os_a,
   input  os_e  i_os_b,
   output logic o_tmo
);

   os_e  act;
   logic tmo_d;
   logic tmo_q;

   // B takes precedence on a simultaneous match unless it has no action programmed
   always_comb begin
      act = OS_NONE;
      if (i_match_b && (i_os_b != OS_NONE)) begin
         act = i_os_b;
      end else if (i_match_a) begin
         act = i_os_a;
      end
      tmo_d = apply_os(act, tmo_q);
   end

   // Pin register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tmo_q <= TMO_RST;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign o_tmo = tmo_q;

endmodule

// File: rtl/tcnt_count_channel.sv
// One timer channel: TCNT counter, compare A/B match, clear control, overflow,
// sticky status flags, event pulses and the TMO pin.
module tcnt_count_channel
   import timer_pkg::*;
#(
   parameter int   WIDTH   = 8,
   parameter logic TMO_RST = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_tcnt_en,
   input  logic             i_tcnt_wr,
   input  logic [WIDTH-1:0] i_tcnt_wdata,
   input  logic [WIDTH-1:0] i_tcora,
   input  logic [WIDTH-1:0] i_tcorb,
   input  logic [1:0]       i_cclr,
   input  logic             i_tmri,
   input  logic [3:0]       i_os,
   input  logic [2:0]       i_flag_clr,
   output logic [WIDTH-1:0] o_tcnt,
   output logic             o_cmfa,
   output logic             o_cmfb,
   output logic             o_ovf,
   output logic             o_cmia_pulse,
   output logic             o_ovf_pulse,
   output logic             o_cascade,
   output logic             o_tmo
);

   cclr_e                cclr;
   logic                 count_ev;
   logic                 match_a;
   logic                 match_b;
   logic                 tmri_clr;
   logic                 match_clr;
   logic                 ovf_ev;
   logic [NUM_FLAGS-1:0] flag_set;

   logic [WIDTH-1:0]     tcnt_d,  tcnt_q;
   logic [NUM_FLAGS-1:0] flags_d, flags_q;
   logic                 cmia_pulse_q;
   logic                 ovf_pulse_q;

   assign cclr = cclr_e'(i_cclr);

   // A register write steals the cycle from counting and from compare matching
   assign count_ev  = i_tcnt_en & ~i_tcnt_wr;
   assign match_a   = count_ev & (tcnt_q == i_tcora);
   assign match_b   = count_ev & (tcnt_q == i_tcorb);
   assign tmri_clr  = (cclr == CCLR_TMRI) & i_tmri;
   assign match_clr = ((cclr == CCLR_CMA) & match_a) | ((cclr == CCLR_CMB) & match_b);

   // Next counter value; any clear taken at all-ones suppresses the overflow
   always_comb begin
      tcnt_d = tcnt_q;
      ovf_ev = 1'b0;
      if (i_tcnt_wr) begin
         tcnt_d = i_tcnt_wdata;
      end else if (tmri_clr) begin
         tcnt_d = '0;
      end else if (match_clr) begin
         tcnt_d = '0;
      end else if (count_ev) begin
         tcnt_d = tcnt_q + WIDTH'(1);
         ovf_ev = &tcnt_q;
      end
   end

   // Sticky flags: a set in the same cycle as its clear strobe wins
   always_comb begin
      flag_set            = '0;
      flag_set[FLAG_CMFA] = match_a;
      flag_set[FLAG_CMFB] = match_b;
      flag_set[FLAG_OVF]  = ovf_ev;
      flags_d             = (flags_q & ~i_flag_clr) | flag_set;
   end

   // Counter, flag and event-pulse registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tcnt_q       <= '0;
         flags_q      <= '0;
         cmia_pulse_q <= 1'b0;
         ovf_pulse_q  <= 1'b0;
      end else begin
         tcnt_q       <= tcnt_d;
         flags_q      <= flags_d;
         cmia_pulse_q <= match_a;
         ovf_pulse_q  <= ovf_ev;
      end
   end

   tmo_out_ctrl #(
      .TMO_RST (TMO_RST)
   ) u_tmo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_match_a (match_a),
      .i_match_b (match_b),
      .i_os_a    (os_e'(i_os[1:0])),
      .i_os_b    (os_e'(i_os[3:2])),
      .o_tmo     (o_tmo)
   );

   assign o_tcnt       = tcnt_q;
   assign o_cmfa       = flags_q[FLAG_CMFA];
   assign o_cmfb       = flags_q[FLAG_CMFB];
   assign o_ovf        = flags_q[FLAG_OVF];
   assign o_cmia_pulse = cmia_pulse_q;
   assign o_ovf_pulse  = ovf_pulse_q;
   assign o_cascade    = ovf_pulse_q;

endmodule

// File: tb/tb_tcnt_count_channel.sv
// Bench for tcnt_count_channel: directed scenarios followed by random traffic,
// all checked cycle by cycle against an integer reference model.
module tb_tcnt_count_channel;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tcnt_en;
   logic       tcnt_wr;
   logic [7:0] tcnt_wdata;
   logic [7:0] tcora;
   logic [7:0] tcorb;
   logic [1:0] cclr;
   logic       tmri;
   logic [3:0] os;
   logic [2:0] flag_clr;
   logic [7:0] tcnt;
   logic       cmfa, cmfb, ovf, cmia_pulse, ovf_pulse, cascade, tmo;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_tcnt;
   int m_cmfa, m_cmfb, m_ovf, m_cmia_p, m_ovf_p, m_tmo;

   always #5 clk = ~clk;

   tcnt_count_channel #(
      .WIDTH   (8),
      .TMO_RST (1'b0)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_tcnt_en    (tcnt_en),
      .i_tcnt_wr    (tcnt_wr),
      .i_tcnt_wdata (tcnt_wdata),
      .i_tcora      (tcora),
      .i_tcorb      (tcorb),
      .i_cclr       (cclr),
      .i_tmri       (tmri),
      .i_os         (os),
      .i_flag_clr   (flag_clr),
      .o_tcnt       (tcnt),
      .o_cmfa       (cmfa),
      .o_cmfb       (cmfb),
      .o_ovf        (ovf),
      .o_cmia_pulse (cmia_pulse),
      .o_ovf_pulse  (ovf_pulse),
      .o_cascade    (cascade),
      .o_tmo        (tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: advance one clock edge using the inputs present at that edge
   task automatic model_edge();
      int cnt_ev, ma, mb, act, nxt, wrapped;
      cnt_ev = (tcnt_en && !tcnt_wr) ? 1 : 0;
      ma = (cnt_ev == 1 && m_tcnt == int'(tcora)) ? 1 : 0;
      mb = (cnt_ev == 1 && m_tcnt == int'(tcorb)) ? 1 : 0;
      if (!rst_n) begin
         m_tcnt = 0; m_cmfa = 0; m_cmfb = 0; m_ovf = 0;
         m_cmia_p = 0; m_ovf_p = 0; m_tmo = 0;
         return;
      end
      wrapped = 0;
      if (tcnt_wr)                                       nxt = int'(tcnt_wdata);
      else if (cclr == 2'd3 && tmri)                     nxt = 0;
      else if ((cclr == 2'd1 && ma == 1) || (cclr == 2'd2 && mb == 1)) nxt = 0;
      else if (cnt_ev == 1) begin
         nxt = (m_tcnt + 1) % 256;
         wrapped = (m_tcnt == 255) ? 1 : 0;
      end
      else                                               nxt = m_tcnt;
      m_cmfa   = (ma == 1) ? 1 : (flag_clr[0] ? 0 : m_cmfa);
      m_cmfb   = (mb == 1) ? 1 : (flag_clr[1] ? 0 : m_cmfb);
      m_ovf    = (wrapped == 1) ? 1 : (flag_clr[2] ? 0 : m_ovf);
      m_cmia_p = ma;
      m_ovf_p  = wrapped;
      act = 0;
      if (mb == 1 && os[3:2] != 2'd0) act = int'(os[3:2]);
      else if (ma == 1)               act = int'(os[1:0]);
      case (act)
         1: m_tmo = 0;
         2: m_tmo = 1;
         3: m_tmo = 1 - m_tmo;
         default: ;
      endcase
      m_tcnt = nxt;
   endtask

   task automatic compare_all();
      chk("tcnt",       tcnt,       m_tcnt);
      chk("cmfa",       cmfa,       m_cmfa);
      chk("cmfb",       cmfb,       m_cmfb);
      chk("ovf",        ovf,        m_ovf);
      chk("cmia_pulse", cmia_pulse, m_cmia_p);
      chk("ovf_pulse",  ovf_pulse,  m_ovf_p);
      chk("cascade",    cascade,    m_ovf_p);
      chk("tmo",        tmo,        m_tmo);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic quiet();
      tcnt_en = 1'b0; tcnt_wr = 1'b0; tmri = 1'b0; flag_clr = 3'b000;
   endtask

   task automatic load(input logic [7:0] v);
      quiet();
      tcnt_wr = 1'b1; tcnt_wdata = v;
      step();
      tcnt_wr = 1'b0;
   endtask

   initial begin
      m_tcnt = 0; m_cmfa = 0; m_cmfb = 0; m_ovf = 0;
      m_cmia_p = 0; m_ovf_p = 0; m_tmo = 0;
      rst_n = 1'b0; quiet();
      tcnt_wdata = 8'h00; tcora = 8'h00; tcorb = 8'hFF; cclr = 2'b00; os = 4'b0000;
      step(); step();
      chk("rst_tcnt", tcnt, 0);
      chk("rst_tmo",  tmo,  0);
      rst_n = 1'b1;

      // Clear on match A at 5
      tcora = 8'h05; cclr = 2'b01; tcnt_en = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step();
         chk("t1_seq",  tcnt, (i + 1) % 6);
         chk("t1_cmia", cmia_pulse, ((i + 1) % 6 == 0) ? 1 : 0);
      end
      chk("t1_cmfa", cmfa, 1);
      quiet(); flag_clr = 3'b001; step(); flag_clr = 3'b000;
      chk("t1_cmfa_clr", cmfa, 0);

      // Overflow from 0xFE
      cclr = 2'b00;
      load(8'hFE);
      tcnt_en = 1'b1; step();
      chk("t2_ff", tcnt, 8'hFF);
      chk("t2_nopulse", ovf_pulse, 0);
      step();
      chk("t2_wrap", tcnt, 0);
      chk("t2_ovfp", ovf_pulse, 1);
      chk("t2_casc", cascade, 1);
      chk("t2_ovf", ovf, 1);
      quiet(); step();
      chk("t2_ovfp_end", ovf_pulse, 0);

      // Set wins over clear on the OVF flag
      load(8'hFF);
      tcnt_en = 1'b1; flag_clr = 3'b100; step();
      chk("t4_setwins", ovf, 1);
      quiet(); flag_clr = 3'b100; step(); flag_clr = 3'b000;
      chk("t4_clr", ovf, 0);

      // Write beats count and compare
      tcora = 8'h20; cclr = 2'b01;
      load(8'h20);
      tcnt_wr = 1'b1; tcnt_wdata = 8'h40; tcnt_en = 1'b1; step();
      chk("t3_wr", tcnt, 8'h40);
      chk("t3_nomatch", cmfa, 0);
      quiet(); step();
      chk("t3_nopulse", cmia_pulse, 0);

      // Simultaneous A/B match: B toggle wins; then B none lets A apply
      cclr = 2'b00; tcora = 8'h10; tcorb = 8'h10; os = 4'b1110;
      load(8'h10); tcnt_en = 1'b1; step();
      chk("t5_tog1", tmo, 1);
      load(8'h10); tcnt_en = 1'b1; step();
      chk("t5_tog2", tmo, 0);
      os = 4'b0010;
      load(8'h10); tcnt_en = 1'b1; step();
      chk("t5_ahigh", tmo, 1);

      // TMRI clear, then a one-cycle reset mid-count
      cclr = 2'b11;
      load(8'h33);
      tmri = 1'b1; tcnt_en = 1'b1; step(); tmri = 1'b0;
      chk("t6_tmri", tcnt, 0);
      step(); step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("t6_rst_tcnt", tcnt, 0);
      chk("t6_rst_flags", {cmfa, cmfb, ovf}, 0);
      chk("t6_rst_tmo", tmo, 0);
      step();

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 64 == 0) begin
            cclr  = 2'($urandom_range(0, 3));
            os    = 4'($urandom_range(0, 15));
            tcora = 8'($urandom_range(0, 40));
            tcorb = ($urandom_range(0, 3) == 0) ? tcora : 8'($urandom_range(0, 40));
         end
         rst_n    = ($urandom_range(0, 199) != 0);
         tcnt_en  = ($urandom_range(0, 9) < 7);
         tcnt_wr  = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0: tcnt_wdata = 8'hFE;
            1: tcnt_wdata = 8'hFF;
            2: tcnt_wdata = tcora;
            default: tcnt_wdata = 8'($urandom_range(0, 255));
         endcase
         tmri     = ($urandom_range(0, 19) == 0);
         flag_clr = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
